rr_packet_arbiter: RTL and testbench

//  Parametrised N-way arbiter for one switch output port. Selects a single

---
 rtl/rr_packet_arbiter.sv | 114 +++++++++++
 tb/tb_rr_packet_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_packet_arbiter.sv
// Packet arbiter for one switch output port: round-robin or fixed priority, grant held per packet.
// Latency: one cycle from request to grant; handover to the next requester is bubble-free.
// Backpressure: ready_i only qualifies the end-of-packet release; grant is held while ready_i is low.
module rr_packet_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int RR_MODE  = 1,
   parameter int MAX_HOLD = 0,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] request_i,
   input  logic [NUM_REQ-1:0] last_i,
   input  logic               ready_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic               grant_valid_o,
   output logic [IDX_W-1:0]   grant_idx_o
);

   // Counter still needs one bit when the timeout is disabled; it then just saturates at 1.
   localparam int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int HOLD_SAT = (MAX_HOLD > 0) ? MAX_HOLD : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e             state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   ptr_d;
   logic [CNT_W-1:0]   hold_q;

   logic               timeout;
   logic               rel;
   logic [NUM_REQ-1:0] req_m;
   logic [IDX_W-1:0]   base;
   logic [IDX_W-1:0]   cand;
   logic               win_vld;
   logic [IDX_W-1:0]   win_idx;

   // Release detection for the current holder: withdrawal, last beat accepted, or timeout.
   always_comb begin
      ptr_d   = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
      timeout = (MAX_HOLD > 0) && (int'(hold_q) == MAX_HOLD - 1);
      rel     = (state_q == BUSY) &&
                (((request_i & grant_q) == '0) ||
                 (((last_i & grant_q) != '0) && ready_i) ||
                 timeout);
   end

   // Winner search; on release the holder is masked and the search starts just after it.
   always_comb begin
      req_m   = rel ? (request_i & ~grant_q) : request_i;
      base    = rel ? ptr_d : ptr_q;
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (RR_MODE != 0) cand = IDX_W'((int'(base) + k) % NUM_REQ);
         else              cand = IDX_W'(k);
         if (!win_vld && req_m[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Grant FSM: registers grant, index, round-robin pointer and hold counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  state_q <= BUSY;
                  grant_q <= NUM_REQ'(1) << win_idx;
                  idx_q   <= win_idx;
                  hold_q  <= '0;
               end
            end
            BUSY: begin
               if (rel) begin
                  ptr_q  <= ptr_d;
                  hold_q <= '0;
                  if (win_vld) begin
                     grant_q <= NUM_REQ'(1) << win_idx;
                     idx_q   <= win_idx;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= '0;
                     idx_q   <= '0;
                  end
               end else if (hold_q != CNT_W'(HOLD_SAT)) begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant_o       = grant_q;
   assign grant_valid_o = |grant_q;
   assign grant_idx_o   = idx_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Bench for rr_packet_arbiter: three configurations (RR, fixed priority, RR with hold timeout).
// Latency: expectations sampled 1 time unit after each rising edge.
// Backpressure: ready_i driven from vector tables and random stimulus.
module tb_rr_packet_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] last;
   logic       rdy;
   logic [3:0] gnt  [3];
   logic [1:0] gidx [3];
   logic       gv   [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rr_packet_arbiter #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
      .clk_i(clk), .rst_ni(rst_n), .request_i(req), .last_i(last), .ready_i(rdy),
      .grant_o(gnt[0]), .grant_valid_o(gv[0]), .grant_idx_o(gidx[0]));
   rr_packet_arbiter #(.NUM_REQ(4), .RR_MODE(0), .MAX_HOLD(0)) u_fp (
      .clk_i(clk), .rst_ni(rst_n), .request_i(req), .last_i(last), .ready_i(rdy),
      .grant_o(gnt[1]), .grant_valid_o(gv[1]), .grant_idx_o(gidx[1]));
   rr_packet_arbiter #(.NUM_REQ(4), .RR_MODE(1), .MAX_HOLD(3)) u_to (
      .clk_i(clk), .rst_ni(rst_n), .request_i(req), .last_i(last), .ready_i(rdy),
      .grant_o(gnt[2]), .grant_valid_o(gv[2]), .grant_idx_o(gidx[2]));

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++)
         assert ($countones(gnt[i]) <= 1) else $error("grant not one-hot on dut %0d", i);
   end

   // Reference model: current holder (-1 = none), pointer, cycles granted so far.
   int m_g    [3];
   int m_ptr  [3];
   int m_held [3];
   int m_mode [3];
   int m_max  [3];

   function automatic int pick(input logic [3:0] r, input int start, input int mode);
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (mode != 0) ? (start + k) % 4 : k;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         int g;
         int w;
         bit release_now;
         logic [3:0] r;
         g = m_g[i];
         if (g < 0) begin
            w = pick(req, m_ptr[i], m_mode[i]);
            if (w >= 0) begin
               m_g[i]    = w;
               m_held[i] = 1;
            end
         end else begin
            release_now = !req[g] || (last[g] && rdy) ||
                          (m_max[i] > 0 && m_held[i] == m_max[i]);
            if (release_now) begin
               m_ptr[i] = (g + 1) % 4;
               r        = req;
               r[g]     = 1'b0;
               w        = pick(r, m_ptr[i], m_mode[i]);
               m_g[i]   = w;
               m_held[i] = (w >= 0) ? 1 : 0;
            end else begin
               m_held[i] = m_held[i] + 1;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_g[i]    = -1;
         m_ptr[i]  = 0;
         m_held[i] = 0;
      end
   endtask

   // Called just after a rising edge; reset asserts and releases well away from edges.
   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      last  = '0;
      rdy   = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   // One clock: drive inputs, advance the model at the edge, compare all DUTs to the model.
   task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic y, input string tag);
      logic [3:0] eg;
      req  = r;
      last = l;
      rdy  = y;
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < 3; i++) begin
         eg = (m_g[i] < 0) ? 4'b0000 : (4'b0001 << m_g[i]);
         chk($sformatf("%s_model_gnt%0d", tag, i), 32'(gnt[i]), 32'(eg));
         chk($sformatf("%s_model_idx%0d", tag, i), 32'(gidx[i]), (m_g[i] < 0) ? 32'd0 : 32'(m_g[i]));
         chk($sformatf("%s_model_vld%0d", tag, i), 32'(gv[i]), (m_g[i] < 0) ? 32'd0 : 32'd1);
         chk($sformatf("%s_onehot%0d", tag, i), 32'($countones(gnt[i]) <= 1), 32'd1);
      end
   endtask

   typedef struct {
      int         sel;
      bit         rst;
      logic [3:0] req;
      logic [3:0] last;
      logic       rdy;
      logic       vld;
      int         idx;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int sel, input bit rs, input logic [3:0] r,
                               input logic [3:0] l, input logic y, input logic v, input int ix);
      vec_t t;
      t.sel = sel; t.rst = rs; t.req = r; t.last = l; t.rdy = y; t.vld = v; t.idx = ix;
      return t;
   endfunction

   initial begin
      logic [3:0] one;
      logic [3:0] exp_g;
      one = 4'b0001;
      m_mode[0] = 1; m_max[0] = 0;
      m_mode[1] = 0; m_max[1] = 0;
      m_mode[2] = 1; m_max[2] = 3;
      model_reset();

      // Round-robin sweep with every input ending a packet each beat, then withdrawal.
      tbl.push_back(mk(0, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 0));
      tbl.push_back(mk(0, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 1));
      tbl.push_back(mk(0, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2));
      tbl.push_back(mk(0, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 3));
      tbl.push_back(mk(0, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 0));
      tbl.push_back(mk(0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 0));
      // Packet hold on input 1 with ready toggling; last of a non-holder is ignored.
      tbl.push_back(mk(0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1));
      tbl.push_back(mk(0, 1'b0, 4'b1010, 4'b0000, 1'b1, 1'b1, 1));
      tbl.push_back(mk(0, 1'b0, 4'b1010, 4'b0000, 1'b0, 1'b1, 1));
      tbl.push_back(mk(0, 1'b0, 4'b1010, 4'b1000, 1'b1, 1'b1, 1));
      tbl.push_back(mk(0, 1'b0, 4'b1010, 4'b0010, 1'b0, 1'b1, 1));
      tbl.push_back(mk(0, 1'b0, 4'b1010, 4'b0010, 1'b1, 1'b1, 3));
      tbl.push_back(mk(0, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 0));
      // Fixed priority: holder masked once on release, then wins again.
      tbl.push_back(mk(1, 1'b1, 4'b1010, 4'b0000, 1'b1, 1'b1, 1));
      tbl.push_back(mk(1, 1'b0, 4'b1010, 4'b0010, 1'b1, 1'b1, 3));
      tbl.push_back(mk(1, 1'b0, 4'b1010, 4'b1000, 1'b1, 1'b1, 1));
      tbl.push_back(mk(1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 0));
      // Hold timeout of 3 cycles, then the pointer sits at 3.
      tbl.push_back(mk(2, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 2));
      tbl.push_back(mk(2, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2));
      tbl.push_back(mk(2, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2));
      tbl.push_back(mk(2, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 0));
      tbl.push_back(mk(2, 1'b0, 4'b1100, 4'b0000, 1'b1, 1'b1, 3));

      // Reset held with requests active.
      rst_n = 1'b0;
      req   = 4'b1111;
      last  = 4'b1111;
      rdy   = 1'b1;
      #12;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 32'd0);
         chk($sformatf("rst_idx%0d", i), 32'(gidx[i]), 32'd0);
         chk($sformatf("rst_vld%0d", i), 32'(gv[i]), 32'd0);
      end
      req  = '0;
      last = '0;
      rdy  = 1'b0;
      rst_n = 1'b1;
      #1;

      for (int n = 0; n < tbl.size(); n++) begin
         if (tbl[n].rst) do_reset();
         cyc(tbl[n].req, tbl[n].last, tbl[n].rdy, $sformatf("vec%0d", n));
         exp_g = tbl[n].vld ? (one << tbl[n].idx) : 4'b0000;
         chk($sformatf("vec%0d_gnt", n), 32'(gnt[tbl[n].sel]), 32'(exp_g));
         chk($sformatf("vec%0d_idx", n), 32'(gidx[tbl[n].sel]), 32'(tbl[n].idx));
         chk($sformatf("vec%0d_vld", n), 32'(gv[tbl[n].sel]), 32'(tbl[n].vld));
      end

      // Asynchronous reset in the middle of a packet drops the grant before the next edge.
      do_reset();
      cyc(4'b1111, 4'b0000, 1'b0, "busy");
      chk("busy_before_rst", 32'(gv[0]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("async_rst_gnt%0d", i), 32'(gnt[i]), 32'd0);
         chk($sformatf("async_rst_idx%0d", i), 32'(gidx[i]), 32'd0);
      end
      req  = '0;
      last = '0;
      rdy  = 1'b0;
      rst_n = 1'b1;
      model_reset();

      // Random traffic against the model.
      for (int c = 0; c < 1000; c++) begin
         cyc(4'($urandom), 4'($urandom) & 4'($urandom), ($urandom_range(0, 3) != 0),
             $sformatf("rnd%0d", c));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
